ir_decode: RTL and testbench
============================

# ir_decode

Instruction register and opcode decoder for the multicycle MIPS-subset CPU. Sits directly upstream of the control `fsm`. It captures the fetched instruction word from memory when the FSM asserts `IR_WE` in IF. It then presents the registered 4-bit `instr` code, the register fields and the immediate fields that `fsm` and the datapath consume from ID onward. It also flags unsupported encodings and keeps load/illegal statistics.

## Interface
- No parameters; all widths fixed by the ISA.
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `IR_WE`  in  1  instruction-register write enable from `fsm`
- `mem_dout`  in  32  memory read data (fetched instruction word)
- `instr`  out  4  decoded instruction code to `fsm`
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- `imm`  out  16  IR[15:0]
- `imm_se`  out  32  sign-extended `imm`
- `jaddr`  out  26  IR[25:0]
- `ir_valid`  out  1  at least one word loaded since reset
- `illegal`  out  1  current IR holds an unsupported encoding
- `illegal_sticky`  out  1  an illegal word has been loaded since reset
- `load_count`  out  16  number of IR loads since reset
- `illegal_count`  out  8  number of illegal loads (statistics option only)

## Operation
- Single 32-bit IR register plus registered decode outputs. Everything updates only on a `clk` edge with `IR_WE`=1, except `ir_valid`, the counters and the sticky flag (see below).
- Decode is taken from `mem_dout` at the load edge and registered alongside IR. Opcode is bits [31:26]; funct is bits [5:0].
  - XORI: opcode 0x0E → 0
  - LW: opcode 0x23 → 1
  - SW: opcode 0x2B → 2
  - ADD: opcode 0x00, funct 0x20 → 3
  - SUB: opcode 0x00, funct 0x22 → 4
  - SLT: opcode 0x00, funct 0x2A → 5
  - J: opcode 0x02 → 6
  - JAL: opcode 0x03 → 7
  - JR: opcode 0x00, funct 0x08 → 8
  - BNE: opcode 0x05 → 9
- Any other encoding, including every other R-type funct, → `instr`=15 and `illegal`=1. `fsm` treats 15 as return-to-IF.
- `imm_se` = {{16{IR[15]}}, IR[15:0]}.
- `ir_valid`: two-state machine.
  - EMPTY → LOADED on the first `IR_WE`.
  - LOADED is held until `reset`.
- `illegal_sticky` is set on any load that decodes illegal. It clears only on `reset`.
- `load_count` increments by 1 on every `IR_WE` edge. It wraps 0xFFFF→0x0000.
- `IR_WE` held high for consecutive cycles loads every cycle. The last word sampled wins.

## Timing
- Reset values (asynchronous, immediate on `reset` rise):
  - IR=0, `instr`=15, `rs`/`rt`/`rd`=0, `imm`=0, `imm_se`=0, `jaddr`=0
  - `ir_valid`=0, `illegal`=0, `illegal_sticky`=0, `load_count`=0, `illegal_count`=0
- Load latency: one cycle. `mem_dout` sampled at edge N with `IR_WE`=1 appears on all outputs after edge N. It is therefore valid for the whole ID state.
- Outputs are held stable while `IR_WE`=0, regardless of `mem_dout` activity.
- If `reset` is asserted in the same cycle as `IR_WE`, `reset` wins and no load or count occurs.
- Illegal encoding with `IR_WE`: `illegal` reflects only the current IR and clears on the next legal load. `illegal_sticky` does not clear on a later legal load.

## Configuration
- `IR_DECODE_STATS_EN` defined:
  - `illegal_count` is an 8-bit counter, incremented on each illegal load.
  - It saturates at 255 with no wrap.
- `IR_DECODE_STATS_EN` undefined:
  - `illegal_count` is tied to 8'd0 and no counter register is built.
  - All other behaviour is identical.

## Test plan
- Reset, then load with `IR_WE`=1, `mem_dout`=32'h3A22FFFF (XORI, rs=17, rt=2):
  - Before the edge: `instr`=15, `ir_valid`=0.
  - One cycle later: `instr`=0, `rs`=17, `rt`=2, `imm_se`=32'hFFFFFFFF, `ir_valid`=1, `load_count`=1.
- Sweep all ten legal encodings on consecutive `IR_WE` cycles:
  - `instr` follows 0..9 one cycle behind.
  - `load_count` ends at 10 (starting from reset) and `illegal` stays 0.
  - Use 0x8C41_0004 (LW), 0x0C00_0010 (JAL, expect `jaddr`=0x10) and 0x03E0_0008 (JR).
- Load 0x0000_0000 (SLL, illegal), then 0x0022_1820 (ADD):
  - After the first load: `instr`=15, `illegal`=1, `illegal_sticky`=1.
  - After the second: `instr`=3, `rd`=3, `illegal`=0, `illegal_sticky` still 1.
- Load a word, then drop `IR_WE` and toggle `mem_dout` randomly for 5 cycles → all outputs unchanged.
- Assert `reset` mid-run in the same cycle as `IR_WE` → all outputs reach their reset values immediately, and no load is counted.
- With `IR_DECODE_STATS_EN` defined, load 260 illegal words → `illegal_count`=255 (saturated), `load_count`=260.
- With `IR_DECODE_STATS_EN` undefined, repeat the 260 illegal loads → `illegal_count`=0, `load_count`=260.

Source files
------------

// File: rtl/ir_decode_if.sv
// ----------------------------------------------------------------------------
// ir_decode_if : bus between the control FSM / memory side and ir_decode.
// Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface ir_decode_if;
  logic        IR_WE;
  logic [31:0] mem_dout;
  logic [3:0]  instr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] imm_se;
  logic [25:0] jaddr;
  logic        ir_valid;
  logic        illegal;
  logic        illegal_sticky;
  logic [15:0] load_count;
  logic [7:0]  illegal_count;

  modport master (
    output IR_WE, mem_dout,
    input  instr, rs, rt, rd, imm, imm_se, jaddr,
           ir_valid, illegal, illegal_sticky, load_count, illegal_count
  );

  modport slave (
    input  IR_WE, mem_dout,
    output instr, rs, rt, rd, imm, imm_se, jaddr,
           ir_valid, illegal, illegal_sticky, load_count, illegal_count
  );
endinterface

`default_nettype wire

// File: rtl/ir_decode.sv
// ----------------------------------------------------------------------------
// ir_decode : instruction register plus registered opcode decoder for the
//             multicycle MIPS-subset CPU. Optional macro IR_DECODE_STATS_EN
//             builds a saturating illegal-load counter.
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ir_decode (
  input  wire logic    clk,
  input  wire logic    reset,
  ir_decode_if.slave   bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;

  localparam logic [3:0] c_I_XORI    = 4'd0;
  localparam logic [3:0] c_I_LW      = 4'd1;
  localparam logic [3:0] c_I_SW      = 4'd2;
  localparam logic [3:0] c_I_ADD     = 4'd3;
  localparam logic [3:0] c_I_SUB     = 4'd4;
  localparam logic [3:0] c_I_SLT     = 4'd5;
  localparam logic [3:0] c_I_J       = 4'd6;
  localparam logic [3:0] c_I_JAL     = 4'd7;
  localparam logic [3:0] c_I_JR      = 4'd8;
  localparam logic [3:0] c_I_BNE     = 4'd9;
  localparam logic [3:0] c_I_ILLEGAL = 4'd15;

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // Opcode bits are not kept: r_instr already carries everything they encode.
  logic [25:0] r_ir_fields;
  logic [3:0]  r_instr;
  logic        r_illegal;
  logic        r_illegal_sticky;
  logic [15:0] r_load_count;
  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [3:0]  w_code;
  logic        w_illegal;

  assign w_op = bus.mem_dout[31:26];
  assign w_fn = bus.mem_dout[5:0];

  always_comb begin
    w_code = c_I_ILLEGAL;
    case (w_op)
      c_OP_XORI: w_code = c_I_XORI;
      c_OP_LW:   w_code = c_I_LW;
      c_OP_SW:   w_code = c_I_SW;
      c_OP_J:    w_code = c_I_J;
      c_OP_JAL:  w_code = c_I_JAL;
      c_OP_BNE:  w_code = c_I_BNE;
      c_OP_RTYPE: begin
        case (w_fn)
          c_FN_ADD: w_code = c_I_ADD;
          c_FN_SUB: w_code = c_I_SUB;
          c_FN_SLT: w_code = c_I_SLT;
          c_FN_JR:  w_code = c_I_JR;
          default:  w_code = c_I_ILLEGAL;
        endcase
      end
      default: w_code = c_I_ILLEGAL;
    endcase
  end

  assign w_illegal = (w_code == c_I_ILLEGAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir_fields <= 26'd0;
      r_instr     <= c_I_ILLEGAL;
      r_illegal   <= 1'b0;
    end else if (bus.IR_WE) begin
      r_ir_fields <= bus.mem_dout[25:0];
      r_instr     <= w_code;
      r_illegal   <= w_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal_sticky <= 1'b0;
      r_load_count     <= 16'd0;
    end else if (bus.IR_WE) begin
      r_load_count <= r_load_count + 16'd1;
      if (w_illegal) begin
        r_illegal_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY:  if (bus.IR_WE) w_state_next = ST_LOADED;
      ST_LOADED: w_state_next = ST_LOADED;
      default:   w_state_next = ST_EMPTY;
    endcase
  end

`ifdef IR_DECODE_STATS_EN
  logic [7:0] r_illegal_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal_count <= 8'd0;
    end else if (bus.IR_WE && w_illegal && (r_illegal_count != 8'hFF)) begin
      r_illegal_count <= r_illegal_count + 8'd1;
    end
  end

  assign bus.illegal_count = r_illegal_count;
`else
  assign bus.illegal_count = 8'd0;
`endif

  assign bus.instr          = r_instr;
  assign bus.rs             = r_ir_fields[25:21];
  assign bus.rt             = r_ir_fields[20:16];
  assign bus.rd             = r_ir_fields[15:11];
  assign bus.imm            = r_ir_fields[15:0];
  assign bus.imm_se         = {{16{r_ir_fields[15]}}, r_ir_fields[15:0]};
  assign bus.jaddr          = r_ir_fields[25:0];
  assign bus.ir_valid       = (r_state == ST_LOADED);
  assign bus.illegal        = r_illegal;
  assign bus.illegal_sticky = r_illegal_sticky;
  assign bus.load_count     = r_load_count;

endmodule

`default_nettype wire

// File: tb/tb_ir_decode.sv
// ----------------------------------------------------------------------------
// tb_ir_decode : self-checking bench for ir_decode against a table-driven model.
// Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ir_decode;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ir_decode_if bus ();

  ir_decode u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IR_DECODE_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  // Legal instruction table: entry index is the instr code.
  logic [5:0] op_tab [10] = '{6'h0E, 6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h00, 6'h05};
  logic [5:0] fn_tab [10] = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h2A, 6'h00, 6'h00, 6'h08, 6'h00};

  logic [31:0] m_ir;
  bit          m_valid;
  bit          m_sticky;
  logic [15:0] m_cnt;
  int          m_ill;

  function automatic int ref_code(input logic [31:0] w);
    for (int i = 0; i < 10; i++) begin
      if (w[31:26] == op_tab[i] && (op_tab[i] != 6'h00 || w[5:0] == fn_tab[i])) return i;
    end
    return 15;
  endfunction

  function automatic void model_reset();
    m_ir = 32'd0; m_valid = 0; m_sticky = 0; m_cnt = 16'd0; m_ill = 0;
  endfunction

  function automatic void model_load(input logic [31:0] w);
    m_ir = w;
    m_valid = 1;
    m_cnt = m_cnt + 16'd1;
    if (ref_code(w) == 15) begin
      m_sticky = 1;
      if (m_ill < 255) m_ill++;
    end
  endfunction

  function automatic logic [31:0] exp_imm_se();
    logic [15:0] lo;
    lo = m_ir[15:0];
    return {{16{lo[15]}}, lo};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.IR_WE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drives one load cycle and leaves sampling point at posedge+1.
  task automatic drive_load(input logic [31:0] w);
    @(negedge clk);
    bus.IR_WE = 1'b1;
    bus.mem_dout = w;
    @(posedge clk);
    model_load(w);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    tests++;
    if (bus.instr !== 4'd15 || bus.rs !== 5'd0 || bus.rt !== 5'd0 || bus.rd !== 5'd0 ||
        bus.imm !== 16'd0 || bus.imm_se !== 32'd0 || bus.jaddr !== 26'd0) begin
      fails++;
      $display("FAIL reset_fields: instr=%0d rs=%0d rt=%0d rd=%0d imm=%h jaddr=%h, need 15/0/0/0/0/0",
               bus.instr, bus.rs, bus.rt, bus.rd, bus.imm, bus.jaddr);
    end
    tests++;
    if (bus.ir_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.illegal_sticky !== 1'b0 ||
        bus.load_count !== 16'd0 || bus.illegal_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_status: valid=%b ill=%b sticky=%b cnt=%0d icnt=%0d, need all 0",
               bus.ir_valid, bus.illegal, bus.illegal_sticky, bus.load_count, bus.illegal_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_load();
    do_reset();
    bus.IR_WE = 1'b1;
    bus.mem_dout = 32'h3A22FFFF;
    #1;
    tests++;
    if (bus.instr !== 4'd15 || bus.ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL pre_edge: instr=%0d valid=%b, need 15/0", bus.instr, bus.ir_valid);
    end
    @(posedge clk);
    model_load(32'h3A22FFFF);
    #1;
    tests++;
    if (bus.instr !== 4'd0 || bus.rs !== 5'd17 || bus.rt !== 5'd2 || bus.imm_se !== 32'hFFFFFFFF ||
        bus.ir_valid !== 1'b1 || bus.load_count !== 16'd1) begin
      fails++;
      $display("FAIL first_load: instr=%0d rs=%0d rt=%0d imm_se=%h valid=%b cnt=%0d, need 0/17/2/ffffffff/1/1",
               bus.instr, bus.rs, bus.rt, bus.imm_se, bus.ir_valid, bus.load_count);
    end
    @(negedge clk);
    bus.IR_WE = 1'b0;
  endtask

  task automatic test_legal_sweep();
    logic [31:0] words [10] = '{32'h3A22FFFF, 32'h8C410004, 32'hAC410004, 32'h00221820, 32'h00221822,
                                32'h0022182A, 32'h08000020, 32'h0C000010, 32'h03E00008, 32'h1441FFFE};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_load(words[i]);
      tests++;
      if (bus.instr !== 4'(i) || bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL sweep_%0d: instr=%0d ill=%b, need %0d/0", i, bus.instr, bus.illegal, i);
      end
      if (i == 1) begin
        tests++;
        if (bus.rs !== 5'd2 || bus.rt !== 5'd1 || bus.imm_se !== 32'd4) begin
          fails++;
          $display("FAIL sweep_lw_fields: rs=%0d rt=%0d imm_se=%h, need 2/1/4", bus.rs, bus.rt, bus.imm_se);
        end
      end
      if (i == 7) begin
        tests++;
        if (bus.jaddr !== 26'h10) begin
          fails++;
          $display("FAIL sweep_jal_jaddr: got %h need 10", bus.jaddr);
        end
      end
    end
    tests++;
    if (bus.load_count !== 16'd10 || bus.illegal_sticky !== 1'b0) begin
      fails++;
      $display("FAIL sweep_count: cnt=%0d sticky=%b, need 10/0", bus.load_count, bus.illegal_sticky);
    end
    @(negedge clk);
    bus.IR_WE = 1'b0;
  endtask

  task automatic test_illegal();
    drive_load(32'h00000000);
    tests++;
    if (bus.instr !== 4'd15 || bus.illegal !== 1'b1 || bus.illegal_sticky !== 1'b1) begin
      fails++;
      $display("FAIL illegal_sll: instr=%0d ill=%b sticky=%b, need 15/1/1", bus.instr, bus.illegal, bus.illegal_sticky);
    end
    drive_load(32'h00221820);
    tests++;
    if (bus.instr !== 4'd3 || bus.rd !== 5'd3 || bus.illegal !== 1'b0 || bus.illegal_sticky !== 1'b1) begin
      fails++;
      $display("FAIL illegal_then_add: instr=%0d rd=%0d ill=%b sticky=%b, need 3/3/0/1",
               bus.instr, bus.rd, bus.illegal, bus.illegal_sticky);
    end
    @(negedge clk);
    bus.IR_WE = 1'b0;
  endtask

  task automatic test_hold();
    drive_load(32'h8CA5_8001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.IR_WE = 1'b0;
      bus.mem_dout = $urandom;
      @(posedge clk);
      #1;
      tests++;
      if (bus.instr !== 4'(ref_code(m_ir)) || bus.jaddr !== m_ir[25:0] || bus.imm_se !== exp_imm_se() ||
          bus.load_count !== m_cnt || bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: instr=%0d jaddr=%h cnt=%0d, need %0d/%h/%0d",
                 i, bus.instr, bus.jaddr, bus.load_count, ref_code(m_ir), m_ir[25:0], m_cnt);
      end
    end
  endtask

  task automatic test_reset_during_load();
    drive_load(32'hFC00_0000);
    @(negedge clk);
    bus.IR_WE = 1'b1;
    bus.mem_dout = 32'h0022_1822;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    tests++;
    if (bus.instr !== 4'd15 || bus.jaddr !== 26'd0 || bus.ir_valid !== 1'b0 || bus.illegal_sticky !== 1'b0 ||
        bus.illegal !== 1'b0 || bus.load_count !== 16'd0 || bus.illegal_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_async: instr=%0d jaddr=%h valid=%b sticky=%b cnt=%0d, need 15/0/0/0/0",
               bus.instr, bus.jaddr, bus.ir_valid, bus.illegal_sticky, bus.load_count);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.load_count !== 16'd0 || bus.instr !== 4'd15 || bus.ir_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins: cnt=%0d instr=%0d valid=%b, need 0/15/0", bus.load_count, bus.instr, bus.ir_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.IR_WE = 1'b0;
  endtask

  task automatic test_stats();
    int exp_ic;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive_load({6'h3F, 26'($urandom)});
    end
    exp_ic = c_STATS ? m_ill : 0;
    tests++;
    if (bus.load_count !== 16'd260 || bus.illegal_count !== 8'(exp_ic) || exp_ic != (c_STATS ? 255 : 0)) begin
      fails++;
      $display("FAIL stats_sat: cnt=%0d icnt=%0d, need 260/%0d", bus.load_count, bus.illegal_count, exp_ic);
    end
    @(negedge clk);
    bus.IR_WE = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        w = $urandom;
        w[31:26] = op_tab[k];
        if (op_tab[k] == 6'h00) w[5:0] = fn_tab[k];
      end else begin
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:26] = 6'h00;
      end
      @(negedge clk);
      bus.IR_WE = ($urandom_range(0, 3) != 0);
      bus.mem_dout = w;
      @(posedge clk);
      if (bus.IR_WE) model_load(w);
      #1;
      tests++;
      if (bus.instr !== 4'(m_valid ? ref_code(m_ir) : 15) || bus.rs !== m_ir[25:21] || bus.rt !== m_ir[20:16] ||
          bus.rd !== m_ir[15:11] || bus.imm !== m_ir[15:0] || bus.imm_se !== exp_imm_se() ||
          bus.jaddr !== m_ir[25:0] || bus.ir_valid !== m_valid ||
          bus.illegal !== (m_valid && ref_code(m_ir) == 15) || bus.illegal_sticky !== m_sticky ||
          bus.load_count !== m_cnt || bus.illegal_count !== 8'(c_STATS ? m_ill : 0)) begin
        fails++;
        $display("FAIL random_%0d: ir_word=%h instr=%0d ill=%b sticky=%b cnt=%0d icnt=%0d, need instr=%0d sticky=%b cnt=%0d",
                 i, m_ir, bus.instr, bus.illegal, bus.illegal_sticky, bus.load_count, bus.illegal_count,
                 m_valid ? ref_code(m_ir) : 15, m_sticky, m_cnt);
      end
    end
    @(negedge clk);
    bus.IR_WE = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.IR_WE = 1'b0;
    bus.mem_dout = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_first_load();
    test_legal_sweep();
    test_illegal();
    test_hold();
    test_reset_during_load();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
